// File: rtl/ev_counter_ctrl.sv
// Command sequencer for the event-counter datapath: loads the counter, paces up/down
// counting through a live prescaler and pulses done when the terminal count is reached.
module ev_counter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [WIDTH-1:0]      cmd_data,
  input  logic [PRESCALE_W-1:0] presc,
  input  logic [WIDTH-1:0]      cnt_value,
  output logic                  cnt_en,
  output logic                  cnt_dir,
  output logic                  cnt_load,
  output logic [WIDTH-1:0]      cnt_load_val,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] OP_START_UP   = 2'b00;
  localparam logic [1:0] OP_START_DOWN = 2'b01;
  localparam logic [1:0] OP_STOP       = 2'b10;
  localparam logic [1:0] OP_LOAD       = 2'b11;

  state_e                state_q;
  logic [PRESCALE_W-1:0] psc_q;
  logic [WIDTH-1:0]      tc_q;
  logic                  dir_q;
  logic [WIDTH-1:0]      load_val_q;

  logic cmd_accept;
  logic psc_wrap;
  logic at_tc;

  assign cmd_ready  = ena & ((state_q == ST_IDLE) | (state_q == ST_RUN));
  assign cmd_accept = cmd_valid & cmd_ready;
  // >= rather than == so a prescaler lowered mid-run wraps on the next cycle
  assign psc_wrap   = (psc_q >= presc);
  assign at_tc      = (cnt_value == tc_q);

  assign cnt_en       = ena & (state_q == ST_RUN) & psc_wrap & ~at_tc & ~cmd_accept;
  assign cnt_load     = ena & (state_q == ST_LOAD);
  assign done         = ena & (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign state        = state_q;
  assign cnt_dir      = dir_q;
  assign cnt_load_val = load_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      psc_q      <= '0;
      tc_q       <= '0;
      dir_q      <= 1'b0;
      load_val_q <= '0;
    end else if (ena) begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_accept) begin
            case (cmd_op)
              OP_LOAD: begin
                load_val_q <= cmd_data;
                state_q    <= ST_LOAD;
              end
              OP_START_UP, OP_START_DOWN: begin
                tc_q    <= cmd_data;
                dir_q   <= (cmd_op == OP_START_UP);
                psc_q   <= '0;
                state_q <= ST_RUN;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_LOAD: state_q <= ST_IDLE;
        ST_RUN: begin
          // an accepted command always wins over terminal-count detection
          if (cmd_accept) begin
            case (cmd_op)
              OP_STOP: state_q <= ST_IDLE;
              OP_LOAD: begin
                load_val_q <= cmd_data;
                state_q    <= ST_LOAD;
              end
              default: begin
                tc_q    <= cmd_data;
                dir_q   <= (cmd_op == OP_START_UP);
                psc_q   <= '0;
                state_q <= ST_RUN;
              end
            endcase
          end else if (at_tc) begin
            state_q <= ST_DONE;
          end else begin
            psc_q <= psc_wrap ? '0 : psc_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ev_counter_ctrl.sv
// Scoreboard bench for ev_counter_ctrl: a behavioural model predicts every strobe,
// load pulse and done pulse with its cycle; a negedge monitor pops and compares.
module tb_ev_counter_ctrl;
  localparam int W  = 8;
  localparam int PW = 4;

  localparam logic [1:0] OP_UP   = 2'b00;
  localparam logic [1:0] OP_DN   = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_data = '0;
  logic [PW-1:0] presc = '0;
  logic [W-1:0]  cnt_value = '0;
  logic          cnt_en, cnt_dir, cnt_load, busy, done;
  logic [W-1:0]  cnt_load_val;
  logic [1:0]    state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_val = '0;

  typedef struct {
    int          kind;   // 0 strobe, 1 load pulse, 2 done pulse
    logic        dir;
    logic [W-1:0] val;
    int          cyc;    // negedge cycle index, -1 = untimed
  } ev_t;
  ev_t sb[$];

  ev_counter_ctrl #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .presc(presc), .cnt_value(cnt_value),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // counter datapath: wraps modulo 2^W
  always @(posedge clk) begin
    if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= cnt_dir ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // monitor
  int      m_kind;
  int      m_sum;
  logic [W-1:0] m_val;
  ev_t     m_e;
  always @(negedge clk) begin
    if (rst_n && (cnt_en || cnt_load || done)) begin
      m_kind = cnt_en ? 0 : (cnt_load ? 1 : 2);
      m_val  = cnt_load ? cnt_load_val : cnt_value;
      m_sum  = int'(cnt_en) + int'(cnt_load) + int'(done);
      chk("single_event", m_sum, 1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event kind=%0d value=0x%0h cyc=%0d required=no event",
                 m_kind, m_val, cyc);
      end else begin
        m_e = sb.pop_front();
        chk("event_kind", m_kind, m_e.kind);
        chk("event_value", m_val, m_e.val);
        if (m_e.kind == 0) chk("strobe_dir", cnt_dir, m_e.dir);
        if (m_e.cyc >= 0) chk("event_cycle", cyc, m_e.cyc);
      end
    end
  end

  // reference model: a run from start to tc takes |distance| mod 2^W steps,
  // spaced presc+1 cycles apart, and done follows two cycles after the last step
  task automatic predict_run(input logic [W-1:0] start, input logic [W-1:0] tc,
                             input bit up, input int p, input int acc, input bit timed);
    int n, last, c;
    logic [W-1:0] v;
    n = up ? int'(W'(tc - start)) : int'(W'(start - tc));
    v = start;
    last = acc;
    for (int i = 0; i < n; i++) begin
      c = acc + 1 + p + i * (p + 1);
      sb.push_back('{kind: 0, dir: up, val: v, cyc: timed ? c : -1});
      v = up ? v + 8'd1 : v - 8'd1;
      last = c;
    end
    sb.push_back('{kind: 2, dir: 1'b0, val: tc, cyc: timed ? last + 2 : -1});
    exp_val = tc;
  endtask

  task automatic predict_load(input logic [W-1:0] val, input int acc);
    sb.push_back('{kind: 1, dir: 1'b0, val: val, cyc: acc + 1});
    exp_val = val;
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [W-1:0] data, output int acc);
    int guard;
    guard = 0;
    acc = -1;
    while (!cmd_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", cmd_ready, 1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      acc = cyc;
      #1 cmd_valid = 1'b0;
      $display("cmd op=%0d data=0x%02h presc=%0d accepted at edge %0d", op, data, presc, acc);
    end
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while ((busy || sb.size() != 0) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_idle"}, {busy, sb.size() != 0}, 2'b00);
  endtask

  int acc, acc2;
  int held_state;
  logic [W-1:0] v, tc;
  bit up;
  int r, p;

  initial begin
    // reset with ena high
    #1;
    chk("rst_outputs", {cnt_en, cnt_load, done, busy}, 4'b0000);
    chk("rst_state", state, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // LOAD in IDLE
    issue(OP_LOAD, 8'h05, acc);
    predict_load(8'h05, acc);
    chk("load_state_1", state, 1);
    @(posedge clk); #1;
    chk("load_state_0", state, 0);
    wait_idle("load");
    chk("load_value", cnt_value, exp_val);

    // START_UP 5 -> 8 back-to-back strobes, then zero-strobe run
    presc = 0;
    issue(OP_UP, 8'd8, acc);
    predict_run(exp_val, 8'd8, 1'b1, 0, acc, 1'b1);
    wait_idle("up8");
    chk("up8_value", cnt_value, exp_val);
    issue(OP_UP, 8'd8, acc);
    predict_run(exp_val, 8'd8, 1'b1, 0, acc, 1'b1);
    wait_idle("up8_zero");

    // presc=3 down count
    issue(OP_LOAD, 8'd5, acc);
    predict_load(8'd5, acc);
    wait_idle("load5");
    presc = 3;
    issue(OP_DN, 8'd2, acc);
    predict_run(exp_val, 8'd2, 1'b0, 3, acc, 1'b1);
    wait_idle("down2");
    chk("down2_value", cnt_value, exp_val);

    // wrap-around up count
    presc = 1;
    issue(OP_LOAD, 8'hFE, acc);
    predict_load(8'hFE, acc);
    wait_idle("loadFE");
    issue(OP_UP, 8'h01, acc);
    predict_run(exp_val, 8'h01, 1'b1, 1, acc, 1'b1);
    wait_idle("wrap");
    chk("wrap_value", cnt_value, exp_val);

    // STOP after four strobes
    presc = 0;
    issue(OP_LOAD, 8'd0, acc);
    predict_load(8'd0, acc);
    wait_idle("load0");
    issue(OP_UP, 8'd200, acc);
    predict_run(exp_val, 8'd200, 1'b1, 0, acc, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    issue(OP_STOP, 8'd0, acc2);
    sb.delete();
    exp_val = 8'd4;
    chk("stop_state", state, 0);
    chk("stop_value", cnt_value, exp_val);
    repeat (3) @(posedge clk);
    #1;

    // retarget mid-run: up from 10 for three strobes, then down to 5
    issue(OP_LOAD, 8'd10, acc);
    predict_load(8'd10, acc);
    wait_idle("load10");
    issue(OP_UP, 8'd50, acc);
    predict_run(exp_val, 8'd50, 1'b1, 0, acc, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    issue(OP_DN, 8'd5, acc2);
    sb.delete();
    chk("retarget_value", cnt_value, 8'd13);
    predict_run(8'd13, 8'd5, 1'b0, 0, acc2, 1'b1);
    wait_idle("retarget");
    chk("retarget_final", cnt_value, exp_val);

    // ena freeze mid-run
    presc = 1;
    issue(OP_LOAD, 8'd0, acc);
    predict_load(8'd0, acc);
    wait_idle("load0b");
    issue(OP_UP, 8'd20, acc);
    predict_run(exp_val, 8'd20, 1'b1, 1, acc, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    ena = 1'b0;
    held_state = int'(state);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("freeze_outputs", {cnt_en, cnt_load, done, cmd_ready}, 4'b0000);
      chk("freeze_state", state, held_state);
    end
    @(posedge clk); #1;
    ena = 1'b1;
    wait_idle("freeze");
    chk("freeze_value", cnt_value, exp_val);

    // asynchronous reset mid-run
    presc = 0;
    issue(OP_LOAD, 8'd0, acc);
    predict_load(8'd0, acc);
    wait_idle("load0c");
    issue(OP_UP, 8'd200, acc);
    predict_run(exp_val, 8'd200, 1'b1, 0, acc, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {cnt_en, cnt_load, done, busy}, 4'b0000);
    chk("midrst_state", state, 0);
    sb.delete();
    chk("midrst_value", cnt_value, 8'd3);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_idle", state, 0);

    // randomized runs
    for (int it = 0; it < 24; it++) begin
      v = 8'($urandom_range(0, 255));
      if (it % 4 == 0) v = 8'hF8 + 8'($urandom_range(0, 7));
      up = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      tc = up ? v + 8'(r) : v - 8'(r);
      p = $urandom_range(0, 3);
      presc = 4'(p);
      issue(OP_LOAD, v, acc);
      predict_load(v, acc);
      wait_idle("rnd_load");
      issue(up ? OP_UP : OP_DN, tc, acc);
      predict_run(exp_val, tc, up, p, acc, 1'b1);
      wait_idle("rnd_run");
      chk("rnd_value", cnt_value, exp_val);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
